regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's integer register file: 2 async read ports, 1 sync write port, and a per-register busy scoreboard for in-flight writebacks.
- After reset, a sequential init sweep loads every register with a deterministic value. A ready flag gates decode while the sweep runs.
- Sits between decode (read, issue) and writeback (write, busy clear) in the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, at least 2.
- AW, 5, address width; must equal log2(NREGS).
- INIT_MODE, 1, init sweep value: 0 = all zero; 1 = reg[i] = i zero-extended to XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  1  write enable (writeback).
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- ra1  in  AW  read address 1.
- ra2  in  AW  read address 2.
- rd1  out  XLEN  read data 1 (combinational).
- rd2  out  XLEN  read data 2 (combinational).
- iss_valid  in  1  issue strobe; marks iss_rd pending.
- iss_rd  in  AW  destination register of the issued instruction.
- busy1  out  1  reg[ra1] has a pending write.
- busy2  out  1  reg[ra2] has a pending write.
- ready  out  1  init sweep complete; file usable.

Behaviour:
- Reset: one clock, rst synchronous active-high.
  - Edge with rst=1 sets state=INIT, cnt=0, ready=0, all busy bits=0.
  - Register contents are not touched by reset itself.
  - Reset mid-operation (mid-sweep or in RUN) restarts the sweep and drops all pending busy bits.
- States: INIT, RUN.
- INIT:
  - Each edge with rst=0 writes reg[cnt] = INIT_MODE ? cnt : 0, then cnt++.
  - On the edge that writes reg[NREGS-1], go to RUN and set ready=1.
  - ready therefore rises exactly NREGS edges after the first edge with rst=0.
  - While INIT: we and iss_valid are ignored; rd1, rd2, busy1, busy2 all read 0.
- RUN:
  - On the edge with we=1 and wa!=0: reg[wa] <= wd.
  - Writes to address 0 are dropped; reg[0] always holds 0.
  - rd1 = (ra1==0) ? 0 : reg[ra1]; same for rd2 with ra2. Zero-latency combinational reads.
- Scoreboard (RUN only):
  - busy[n] set on the edge with iss_valid=1, iss_rd=n, n!=0.
  - busy[n] cleared on the edge with we=1, wa=n.
  - Set and clear of the same n on the same edge: set wins (back-to-back issue to the same rd).
  - Set and clear of different registers on the same edge: both take effect.
  - busy[0] is constant 0; iss_rd=0 is ignored.
  - busy1 = busy[ra1], busy2 = busy[ra2] (subject to the bypass rule below).
- Width rules:
  - wd is stored unmodified.
  - In the INIT_MODE=1 sweep value, cnt is truncated/zero-extended to XLEN.
- Only a single write port exists. An address out of range cannot occur, since AW = log2(NREGS).

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - In RUN, if we=1, wa!=0 and wa==ra1 in the same cycle, rd1=wd and busy1=0, unless iss_valid=1 with iss_rd==ra1 that cycle.
  - Same rule for port 2.
  - Write-to-read forwarding therefore has 0 cycles of latency.
- Undefined:
  - rd1/rd2 return the old register value during the write cycle; the new value is visible from the next cycle.
  - busy1/busy2 drop one cycle after the clearing write.

Test Plan:
- Init: hold rst=1 for 2 edges, release; ready=0 for 32 edges, then 1. With INIT_MODE=1, ra1=5 → rd1=0x5 and ra2=31 → rd2=0x1F. During the sweep, rd1=0 and a write we=1, wa=3, wd=0xAA is ignored (reg3 still 0x3 afterwards).
- x0 hardwire: in RUN, write wa=0, wd=0xFFFFFFFF → ra1=0 reads 0. Issue iss_rd=0 → busy1=0 with ra1=0.
- Scoreboard: issue iss_rd=7 → next cycle busy1=1 with ra1=7. Write wa=7, wd=0x1234 → busy1=0 and rd1=0x1234 next cycle. Same edge issue rd=7 plus write wa=7 → busy stays 1.
- Bypass: write wa=9, wd=0xDEAD with ra1=9 in the same cycle. With REGFILE_WB_BYPASS_EN, rd1=0xDEAD that cycle. Without it, rd1=0x9 that cycle and 0xDEAD the next.
- Mid-run reset: set busy on regs 4 and 6, write reg2=0x55, assert rst for 1 edge → ready=0 and busy clear. After 32 edges, reg2 reads 0x2 again.
- Parametrised build: XLEN=64, NREGS=16, AW=4, INIT_MODE=0 → ready after 16 edges; all regs read 0. Write wa=15, wd=0x0123456789ABCDEF → read back exactly.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with two combinational read ports,
// one synchronous write port and a per-register busy scoreboard that tracks
// in-flight writebacks. After reset, a sequential sweep loads every register
// with a deterministic value. The ready output stays low until that sweep
// has finished.
//
// Optional feature (macro REGFILE_WB_BYPASS_EN): same-cycle forwarding of the
// writeback data and busy clear onto the read ports. When the macro is
// undefined, a write becomes visible on the read ports on the next cycle.
module regfile_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int AW        = 5,
    parameter int INIT_MODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            busy1,
    output logic            busy2,
    output logic            ready
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [XLEN-1:0]   init_value;
    logic              wr_run;
    logic              iss_run;

    // Reject parameter combinations where the address width cannot cover
    // exactly the register count.
    if (AW != $clog2(NREGS) || NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_params
        $error("regfile_scoreboard: NREGS must be a power of two >= 2 and AW must equal log2(NREGS)");
    end

    // The sweep value is either zero or the register index. The index is
    // zero-extended to XLEN, or truncated when XLEN is narrower than AW.
    always_comb begin
        init_value = '0;
        if (INIT_MODE != 0) begin
            init_value = XLEN'(cnt);
        end
    end

    // Writes and issues are accepted only in RUN. Address 0 is never a
    // destination, so the file can treat it as a hard-wired zero.
    assign wr_run  = (state == RUN) && we && (wa != '0);
    assign iss_run = (state == RUN) && iss_valid && (iss_rd != '0);

    // Init/run sequencer. A reset restarts the sweep from register 0. The
    // ready flag is registered and rises together with the move to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Register storage. Reset does not clear it. The sweep writes one
    // register per cycle in INIT, and writeback writes it in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                regs[cnt] <= init_value;
            end else if (wr_run) begin
                regs[wa] <= wd;
            end
        end
    end

    // Next scoreboard value. A writeback clears its bit first, so an issue
    // to the same register on the same edge wins and leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (wr_run) begin
            busy_next[wa] = 1'b0;
        end
        if (iss_run) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state. Reset drops every pending bit, and the bits are
    // frozen outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (state == RUN) begin
            busy <= busy_next;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic byp1;
    logic byp2;

    // A write to the register being read forwards its data and retires the
    // busy bit in the same cycle. An issue to that register in the same
    // cycle keeps the register pending, so in that case nothing is forwarded.
    assign byp1 = wr_run && (wa == ra1) && !(iss_valid && (iss_rd == ra1));
    assign byp2 = wr_run && (wa == ra2) && !(iss_valid && (iss_rd == ra2));

    // Read port 1 with writeback forwarding. It reads as zero during the
    // sweep and for address 0.
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (ready && (ra1 != '0)) begin
            rd1   = byp1 ? wd   : regs[ra1];
            busy1 = byp1 ? 1'b0 : busy[ra1];
        end
    end

    // Read port 2 with writeback forwarding. It follows the same rules as
    // port 1.
    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (ready && (ra2 != '0)) begin
            rd2   = byp2 ? wd   : regs[ra2];
            busy2 = byp2 ? 1'b0 : busy[ra2];
        end
    end
`else
    // Read port 1 returns the stored value, so a write shows up one cycle
    // later. It reads as zero during the sweep and for address 0.
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (ready && (ra1 != '0)) begin
            rd1   = regs[ra1];
            busy1 = busy[ra1];
        end
    end

    // Read port 2 follows the same rules as port 1.
    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (ready && (ra2 != '0)) begin
            rd2   = regs[ra2];
            busy2 = busy[ra2];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed bench for regfile_scoreboard. It drives a
// default-parameter instance through the init sweep, the x0 hard-wiring, the
// scoreboard, the write-read timing and a reset in the middle of RUN. A
// second instance (XLEN=64, NREGS=16, INIT_MODE=0) covers a parametrised
// build. Expected values are hand-computed constants.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        busy1;
    logic        busy2;
    logic        ready;

    logic        rst_w;
    logic        we_w;
    logic [3:0]  wa_w;
    logic [63:0] wd_w;
    logic [3:0]  ra1_w;
    logic [3:0]  ra2_w;
    logic [63:0] rd1_w;
    logic [63:0] rd2_w;
    logic        busy1_w;
    logic        busy2_w;
    logic        ready_w;

    int checkCount;
    int errorCount;
    int edges;

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .AW(5), .INIT_MODE(1)
    ) u_dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    regfile_scoreboard #(
        .XLEN(64), .NREGS(16), .AW(4), .INIT_MODE(0)
    ) u_dut_wide (
        .clk(clk), .rst(rst_w), .we(we_w), .wa(wa_w), .wd(wd_w),
        .ra1(ra1_w), .ra2(ra2_w), .rd1(rd1_w), .rd2(rd2_w),
        .iss_valid(1'b0), .iss_rd(4'd0),
        .busy1(busy1_w), .busy2(busy2_w), .ready(ready_w)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the observed and expected
    // values differ.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the write and issue inputs of the main instance, then lets the
    // combinational read paths settle.
    task automatic applyStimulus(input logic w_en, input logic [4:0] w_addr,
                                 input logic [31:0] w_data, input logic i_val,
                                 input logic [4:0] i_rd);
        we        = w_en;
        wa        = w_addr;
        wd        = w_data;
        iss_valid = i_val;
        iss_rd    = i_rd;
        #1;
    endtask

    // Drives both read addresses and lets the read paths settle.
    task automatic setReads(input logic [4:0] a1, input logic [4:0] a2);
        ra1 = a1;
        ra2 = a2;
        #1;
    endtask

    // Runs the main sequence of directed vectors.
    initial begin
        checkCount = 0;
        errorCount = 0;
        rst   = 1'b1;
        rst_w = 1'b1;
        we_w  = 1'b0;
        wa_w  = '0;
        wd_w  = '0;
        ra1_w = '0;
        ra2_w = '0;
        setReads(5'd5, 5'd31);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Reset is held for two edges.
        nextCycle();
        nextCycle();
        checkOutput("reset_ready", {63'd0, ready}, 64'd0);
        checkOutput("reset_busy1", {63'd0, busy1}, 64'd0);

        // Release reset. A write during the sweep must be ignored.
        rst = 1'b0;
        nextCycle();
        edges = 1;
        applyStimulus(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3);
        setReads(5'd3, 5'd31);
        checkOutput("sweep_rd1", rd1, 64'd0);
        checkOutput("sweep_busy1", {63'd0, busy1}, 64'd0);
        checkOutput("sweep_ready", {63'd0, ready}, 64'd0);
        while (!ready && edges < 100) begin
            nextCycle();
            edges++;
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("init_edges", 64'(edges), 64'd32);

        // Sweep contents.
        setReads(5'd5, 5'd31);
        checkOutput("init_r5", rd1, 64'h5);
        checkOutput("init_r31", rd2, 64'h1F);
        setReads(5'd3, 5'd0);
        checkOutput("sweep_write_dropped", rd1, 64'h3);
        checkOutput("busy_after_sweep", {63'd0, busy1}, 64'd0);

        // x0 hard-wiring.
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        setReads(5'd0, 5'd0);
        checkOutput("x0_rd1", rd1, 64'd0);
        checkOutput("x0_busy1", {63'd0, busy1}, 64'd0);

        // Scoreboard set and clear.
        setReads(5'd7, 5'd8);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        checkOutput("iss7_same_cycle", {63'd0, busy1}, 64'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
`ifdef REGFILE_WB_BYPASS_EN
        checkOutput("wb7_busy_same_cycle", {63'd0, busy1}, 64'd0);
        checkOutput("wb7_rd_same_cycle", rd1, 64'h1234);
`else
        checkOutput("wb7_busy_same_cycle", {63'd0, busy1}, 64'd1);
        checkOutput("wb7_rd_same_cycle", rd1, 64'h7);
`endif
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("wb7_busy_cleared", {63'd0, busy1}, 64'd0);
        checkOutput("wb7_rd_new", rd1, 64'h1234);

        // Issue and writeback to the same register on one edge: the issue wins.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        nextCycle();
        applyStimulus(1'b1, 5'd7, 32'h5678, 1'b1, 5'd7);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("same_edge_set_wins", {63'd0, busy1}, 64'd1);
        checkOutput("same_edge_data", rd1, 64'h5678);

        // Clear r8 and set r10 on the same edge. Both take effect.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
        nextCycle();
        setReads(5'd10, 5'd8);
        checkOutput("busy8_set", {63'd0, busy2}, 64'd1);
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd10);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("diff_regs_set10", {63'd0, busy1}, 64'd1);
        checkOutput("diff_regs_clear8", {63'd0, busy2}, 64'd0);

        // Write-to-read timing on register 9.
        setReads(5'd9, 5'd9);
        applyStimulus(1'b1, 5'd9, 32'hDEAD, 1'b0, 5'd0);
`ifdef REGFILE_WB_BYPASS_EN
        checkOutput("bypass_rd1", rd1, 64'hDEAD);
        checkOutput("bypass_rd2", rd2, 64'hDEAD);
`else
        checkOutput("bypass_rd1", rd1, 64'h9);
        checkOutput("bypass_rd2", rd2, 64'h9);
`endif
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("after_write_rd1", rd1, 64'hDEAD);

        // Reset in the middle of RUN.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        nextCycle();
        applyStimulus(1'b1, 5'd2, 32'h55, 1'b0, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        setReads(5'd4, 5'd6);
        checkOutput("pre_rst_busy4", {63'd0, busy1}, 64'd1);
        checkOutput("pre_rst_busy6", {63'd0, busy2}, 64'd1);
        setReads(5'd2, 5'd6);
        checkOutput("pre_rst_r2", rd1, 64'h55);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_ready", {63'd0, ready}, 64'd0);
        checkOutput("mid_rst_busy2", {63'd0, busy2}, 64'd0);
        edges = 0;
        while (!ready && edges < 100) begin
            nextCycle();
            edges++;
        end
        checkOutput("mid_rst_edges", 64'(edges), 64'd32);
        setReads(5'd2, 5'd6);
        checkOutput("mid_rst_r2", rd1, 64'h2);
        checkOutput("mid_rst_busy6_clear", {63'd0, busy2}, 64'd0);
        setReads(5'd4, 5'd0);
        checkOutput("mid_rst_busy4_clear", {63'd0, busy1}, 64'd0);

        // Parametrised build: 64-bit, 16 registers, all-zero sweep.
        nextCycle();
        rst_w = 1'b0;
        edges = 0;
        while (!ready_w && edges < 100) begin
            nextCycle();
            edges++;
        end
        checkOutput("wide_init_edges", 64'(edges), 64'd16);
        for (int i = 1; i < 16; i += 2) begin
            ra1_w = 4'(i);
            ra2_w = 4'(i - 1);
            #1;
            checkOutput("wide_zero_rd1", rd1_w, 64'd0);
            checkOutput("wide_zero_rd2", rd2_w, 64'd0);
        end
        we_w = 1'b1;
        wa_w = 4'd15;
        wd_w = 64'h0123_4567_89AB_CDEF;
        nextCycle();
        we_w  = 1'b0;
        ra1_w = 4'd15;
        #1;
        checkOutput("wide_r15", rd1_w, 64'h0123_4567_89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
